// File: rtl/instruction_fetch_queue.sv
// instruction_fetch_queue
//   Fetch stage for a word-addressed instruction memory. Owns the fetch PC,
//   drives the memory read address and captures returned words into a small
//   prefetch FIFO. Decode receives {PC, instruction} over a valid/ready handshake.
//   Handles memory busywait, the 1-cycle read latency and branch/jump redirects.
//
// Parameters
//   DEPTH     prefetch FIFO entries (power of two, >= 2)
//   RESET_PC  first fetch address after reset (word aligned)
//
// Ports
//   CLK             clock, all state updates on posedge
//   RESET           asynchronous reset, active-low
//   IMEM_ADDRESS    read address to instruction memory
//   IMEM_READ_DATA  read data, captured one posedge after the address is issued
//   IMEM_BUSYWAIT   memory not ready: hold address, capture nothing
//   REDIRECT        taken branch/jump: flush and refetch from REDIRECT_PC
//   REDIRECT_PC     redirect target (bits [1:0] forced to 0)
//   INS_VALID       FIFO head holds a valid instruction
//   INS_READY       decode accepts the head this cycle
//   INS_OUT         instruction at FIFO head
//   INS_PC          PC of instruction at FIFO head
//   DBG_OUT         40-bit debug frame, present only when IFQ_DEBUG_EN is defined
//
// Build option
//   IFQ_DEBUG_EN    adds DBG_OUT = {INS_PC, 8'b00010100} while INS_VALID, else 0

module instruction_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic [31:0] IMEM_ADDRESS,
  input  logic [31:0] IMEM_READ_DATA,
  input  logic        IMEM_BUSYWAIT,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic        INS_VALID,
  input  logic        INS_READY,
  output logic [31:0] INS_OUT,
  output logic [31:0] INS_PC
`ifdef IFQ_DEBUG_EN
  ,
  output logic [39:0] DBG_OUT
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW+1:0] DEPTH_W = (PW+2)'(DEPTH);

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  logic [1:0]    state, state_nxt;
  logic [31:0]   fetch_pc, fetch_pc_nxt;
  logic [31:0]   addr_nxt;
  logic          inflight, inflight_nxt;
  logic [31:0]   tag, tag_nxt;
  logic [31:0]   tgt, tgt_nxt;

  logic [31:0]   mem_ins [DEPTH];
  logic [31:0]   mem_pc  [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   count, count_nxt, remain;
  logic [PW+1:0] credit;

  logic          push, pop, pop_req, flush;
  logic [31:0]   head_ins_nxt, head_pc_nxt;

  assign INS_VALID = (count != '0);
  assign pop_req   = INS_VALID & INS_READY;
  // Slots already promised (queued + in flight) after this cycle's pop.
  assign credit    = (PW+2)'(count) + (PW+2)'(inflight) - (PW+2)'(pop_req);

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    addr_nxt     = IMEM_ADDRESS;
    inflight_nxt = inflight;
    tag_nxt      = tag;
    tgt_nxt      = tgt;
    push         = 1'b0;
    pop          = 1'b0;
    flush        = 1'b0;

    if (state == ST_BOOT) begin
      state_nxt = ST_RUN;
    end else if (REDIRECT) begin
      // Redirect wins over everything: drop queue, in-flight word and any pop.
      flush        = 1'b1;
      inflight_nxt = 1'b0;
      tgt_nxt      = REDIRECT_PC & ~32'd3;
      state_nxt    = ST_FLUSH;
    end else if (state == ST_FLUSH) begin
      addr_nxt     = tgt;
      fetch_pc_nxt = tgt + 32'd4;
      inflight_nxt = 1'b1;
      tag_nxt      = tgt;
      state_nxt    = IMEM_BUSYWAIT ? ST_STALL : ST_RUN;
    end else begin
      pop = pop_req;
      if (IMEM_BUSYWAIT) begin
        state_nxt = ST_STALL;
      end else begin
        push         = inflight;
        inflight_nxt = 1'b0;
        state_nxt    = ST_RUN;
        if (state == ST_RUN && credit < DEPTH_W) begin
          addr_nxt     = fetch_pc;
          fetch_pc_nxt = fetch_pc + 32'd4;
          inflight_nxt = 1'b1;
          tag_nxt      = fetch_pc;
        end
      end
    end
  end

  // Next head: the entry behind a popped head, or the incoming word when the
  // queue would otherwise be empty. An empty queue keeps the last head value.
  always_comb begin
    remain       = count - (PW+1)'(pop);
    count_nxt    = flush ? '0 : remain + (PW+1)'(push);
    head_ins_nxt = INS_OUT;
    head_pc_nxt  = INS_PC;
    if (!flush) begin
      if (remain != '0) begin
        head_ins_nxt = mem_ins[rd_ptr + PW'(pop)];
        head_pc_nxt  = mem_pc[rd_ptr + PW'(pop)];
      end else if (push) begin
        head_ins_nxt = IMEM_READ_DATA;
        head_pc_nxt  = tag;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state        <= ST_BOOT;
      fetch_pc     <= RESET_PC;
      IMEM_ADDRESS <= RESET_PC;
      inflight     <= 1'b0;
      tag          <= '0;
      tgt          <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      INS_OUT      <= '0;
      INS_PC       <= '0;
    end else begin
      state        <= state_nxt;
      fetch_pc     <= fetch_pc_nxt;
      IMEM_ADDRESS <= addr_nxt;
      inflight     <= inflight_nxt;
      tag          <= tag_nxt;
      tgt          <= tgt_nxt;
      count        <= count_nxt;
      INS_OUT      <= head_ins_nxt;
      INS_PC       <= head_pc_nxt;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        rd_ptr <= rd_ptr + PW'(pop);
        wr_ptr <= wr_ptr + PW'(push);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem_ins[wr_ptr] <= IMEM_READ_DATA;
      mem_pc[wr_ptr]  <= tag;
    end
  end

`ifdef IFQ_DEBUG_EN
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      DBG_OUT <= '0;
    end else begin
      DBG_OUT <= (count_nxt != '0) ? {head_pc_nxt, 8'b00010100} : '0;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_queue.sv
module tb_instruction_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        busy, redir, rdy;
  logic [31:0] rpc;
  logic        ins_valid;
  logic [31:0] ins_out, ins_pc;
`ifdef IFQ_DEBUG_EN
  logic [39:0] dbg;
`endif

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  assign imem_data = memf(imem_addr);

  instruction_fetch_queue #(
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .CLK           (clk),
    .RESET         (rst_n),
    .IMEM_ADDRESS  (imem_addr),
    .IMEM_READ_DATA(imem_data),
    .IMEM_BUSYWAIT (busy),
    .REDIRECT      (redir),
    .REDIRECT_PC   (rpc),
    .INS_VALID     (ins_valid),
    .INS_READY     (rdy),
    .INS_OUT       (ins_out),
    .INS_PC        (ins_pc)
`ifdef IFQ_DEBUG_EN
    ,
    .DBG_OUT       (dbg)
`endif
  );

  // Reference model: the queue holds {pc, instruction} pairs; mode is
  // 0 boot, 1 run, 2 stall, 3 flush.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        q[$];
  int          mode;
  logic [31:0] m_addr, m_pc, m_tag, m_tgt, m_hpc, m_hins;
  bit          m_fly;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mode   = 0;
    m_addr = RESET_PC;
    m_pc   = RESET_PC;
    m_fly  = 0;
    m_tag  = '0;
    m_tgt  = '0;
    m_hpc  = '0;
    m_hins = '0;
  endtask

  task automatic model_edge();
    bit popv;
    int used;
    popv = (q.size() != 0) && rdy;
    if (mode == 0) begin
      mode = 1;
    end else if (redir) begin
      q.delete();
      m_fly = 0;
      m_tgt = rpc & ~32'd3;
      mode  = 3;
    end else if (mode == 3) begin
      m_addr = m_tgt;
      m_pc   = m_tgt + 32'd4;
      m_fly  = 1;
      m_tag  = m_tgt;
      mode   = busy ? 2 : 1;
    end else begin
      used = q.size() + int'(m_fly) - int'(popv);
      if (popv) void'(q.pop_front());
      if (busy) begin
        mode = 2;
      end else begin
        if (m_fly) q.push_back({m_tag, memf(m_addr)});
        m_fly = 0;
        if (mode == 1 && used < int'(DEPTH)) begin
          m_fly  = 1;
          m_tag  = m_pc;
          m_addr = m_pc;
          m_pc   = m_pc + 32'd4;
        end
        mode = 1;
      end
    end
    if (q.size() != 0) begin
      m_hpc  = q[0].pc;
      m_hins = q[0].ins;
    end
  endtask

  task automatic check_all();
    chk("addr",  64'(imem_addr), 64'(m_addr));
    chk("valid", 64'(ins_valid), 64'(q.size() != 0));
    chk("pc",    64'(ins_pc),    64'(m_hpc));
    chk("ins",   64'(ins_out),   64'(m_hins));
`ifdef IFQ_DEBUG_EN
    chk("dbg",   64'(dbg), (q.size() != 0) ? 64'({m_hpc, 8'b00010100}) : 64'd0);
`endif
  endtask

  task automatic step(input bit r, input bit b, input bit d, input logic [31:0] p);
    rdy   = r;
    busy  = b;
    redir = d;
    rpc   = p;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Asserts reset between edges, checks the asynchronous effect, holds it over
  // one edge and releases it away from the edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_addr",  64'(imem_addr), 64'(RESET_PC));
    chk("rst_valid", 64'(ins_valid), 64'd0);
    chk("rst_pc",    64'(ins_pc),    64'd0);
    chk("rst_ins",   64'(ins_out),   64'd0);
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    int w;
    w = 0;
    while (!ins_valid && w < 10) begin
      step(1, 0, 0, '0);
      w++;
    end
    if (w >= 10) chk(tag, 64'd0, 64'd1);
  endtask

  initial begin
    int hits;
    rst_n = 1'b0;
    rdy   = 1'b0;
    busy  = 1'b0;
    redir = 1'b0;
    rpc   = '0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // T1: streaming fetch with decode always ready.
    for (int e = 1; e <= 9; e++) begin
      step(1, 0, 0, '0);
      if (e >= 2) chk("t1_addr", 64'(imem_addr), 64'(32'(4 * (e - 2))));
      if (e >= 3) begin
        chk("t1_valid", 64'(ins_valid), 64'd1);
        chk("t1_pc", 64'(ins_pc), 64'(32'(4 * (e - 3))));
      end
    end

    // T2: decode stalled from reset, queue fills to DEPTH, then drains in order.
    do_reset();
    for (int i = 0; i < 10; i++) step(0, 0, 0, '0);
    chk("t2_addr_hold", 64'(imem_addr), 64'h0000000C);
    chk("t2_head", 64'(ins_pc), 64'd0);
    for (int i = 0; i < 8; i++) step(1, 0, 0, '0);

    // T3: busywait while address 8 is in flight.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 0, 0, '0);
    chk("t3_addr8", 64'(imem_addr), 64'h8);
    hits = 0;
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, '0);
      chk("t3_hold", 64'(imem_addr), 64'h8);
      if (ins_valid && ins_pc == 32'h8) hits++;
    end
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0, '0);
      if (ins_valid && ins_pc == 32'h8) hits++;
    end
    chk("t3_once", 64'(hits), 64'd1);

    // T4: redirect with three words queued.
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 0, 0, '0);
    chk("t4_queued", 64'(ins_valid), 64'd1);
    step(0, 0, 1, 32'h43);
    chk("t4_flushed", 64'(ins_valid), 64'd0);
    wait_valid("t4_wait");
    chk("t4_pc0", 64'(ins_pc), 64'h40);
    step(1, 0, 0, '0);
    chk("t4_pc1", 64'(ins_pc), 64'h44);

    // T5: redirect to the last word; fetch PC wraps to zero.
    step(1, 0, 1, 32'hFFFFFFFC);
    wait_valid("t5_wait");
    chk("t5_pc0", 64'(ins_pc), 64'hFFFFFFFC);
    step(1, 0, 0, '0);
    chk("t5_pc1", 64'(ins_pc), 64'h0);

    // T6: reset asserted while stalled.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 0, 0, '0);
    step(1, 1, 0, '0);
    step(1, 1, 0, '0);
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 0, '0);
    chk("t6_refetch", 64'(imem_addr), 64'h4);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      logic [31:0] p;
      if (i % 200 == 199) do_reset();
      p = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 + 32'($urandom_range(0, 15))) : $urandom;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 19) == 0, p);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
